// File: rtl/cbfp_shift_sched.sv
// CBFP shift scheduler: reduces per-beat leading-zero counts to one block shift,
// queues it in a 2-entry FIFO and replays it to the scaler as the delayed beats emerge.
module cbfp_shift_sched #(
  parameter int ARRAY_NUM = 4,
  parameter int DIN_SIZE  = 23,
  parameter int DOUT_SIZE = 11,
  parameter int ZCNT_W    = 5,
  parameter int IDX_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              zcnt_valid,
  input  logic [ZCNT_W-1:0] zcnt_in,
  input  logic              sr_valid,
  output logic              scale_valid,
  output logic [ZCNT_W-1:0] scale_shift,
  output logic [1:0]        scale_beat,
  output logic              blk_done,
  output logic [ZCNT_W-1:0] blk_exp,
  output logic [IDX_W-1:0]  blk_idx,
  output logic [1:0]        fifo_level,
  output logic              err_ovf,
  output logic              err_udf
);

  localparam int MAX_SHIFT = DIN_SIZE - DOUT_SIZE;
  localparam int CNT_W     = (ARRAY_NUM > 1) ? $clog2(ARRAY_NUM) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT   = CNT_W'(ARRAY_NUM - 1);
  localparam logic [ZCNT_W-1:0] MAX_SHIFT_Z = ZCNT_W'(MAX_SHIFT);

  typedef enum logic {O_IDLE, O_RUN} out_state_t;

  out_state_t        state, state_nxt;
  logic [CNT_W-1:0]  in_cnt, out_cnt, out_cnt_nxt;
  logic [ZCNT_W-1:0] run_min, blk_min, push_val;
  logic [ZCNT_W-1:0] fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [ZCNT_W-1:0] cur_shift, start_shift, emit_shift;
  logic              push, start, have_head, bypass, pop, do_push;
  logic              underflow, overflow, emit_last;

  // Running minimum over the block; the last beat folds in without a register hop.
  always_comb begin
    blk_min = zcnt_in;
    if (in_cnt != '0 && run_min < zcnt_in) blk_min = run_min;
    push_val = (blk_min > MAX_SHIFT_Z) ? MAX_SHIFT_Z : blk_min;
  end

  assign push = zcnt_valid && (in_cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt  <= '0;
      run_min <= '0;
    end else if (zcnt_valid) begin
      run_min <= blk_min;
      in_cnt  <= (in_cnt == LAST_BEAT) ? '0 : in_cnt + CNT_W'(1);
    end
  end

  // An empty FIFO can still serve a block start by forwarding the push in flight.
  always_comb begin
    start       = (state == O_IDLE) && sr_valid;
    have_head   = (fifo_level != 2'd0);
    bypass      = start && !have_head && push;
    pop         = start && have_head;
    underflow   = start && !have_head && !push;
    overflow    = push && (fifo_level == 2'd2) && !pop;
    do_push     = push && !bypass && !overflow;
    start_shift = '0;
    if (pop)         start_shift = fifo_mem[rd_ptr];
    else if (bypass) start_shift = push_val;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= O_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      O_IDLE: if (sr_valid && LAST_BEAT != '0) state_nxt = O_RUN;
      O_RUN:  if (sr_valid && out_cnt == LAST_BEAT) state_nxt = O_IDLE;
      default: state_nxt = O_IDLE;
    endcase
  end

  always_comb begin
    emit_shift  = (state == O_IDLE) ? start_shift : cur_shift;
    emit_last   = sr_valid && (out_cnt == LAST_BEAT);
    out_cnt_nxt = out_cnt;
    if (sr_valid) out_cnt_nxt = emit_last ? '0 : out_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt     <= '0;
      cur_shift   <= '0;
      scale_valid <= 1'b0;
      scale_shift <= '0;
      scale_beat  <= '0;
      blk_done    <= 1'b0;
      blk_exp     <= '0;
      blk_idx     <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_level  <= '0;
      err_ovf     <= 1'b0;
      err_udf     <= 1'b0;
    end else begin
      out_cnt     <= out_cnt_nxt;
      scale_valid <= sr_valid;
      scale_shift <= sr_valid ? emit_shift : '0;
      scale_beat  <= sr_valid ? 2'(out_cnt) : 2'd0;
      blk_done    <= emit_last;
      if (start) cur_shift <= start_shift;
      if (emit_last) begin
        blk_exp <= emit_shift;
        blk_idx <= blk_idx + IDX_W'(1);
      end
      if (do_push) begin
        fifo_mem[wr_ptr] <= push_val;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_level <= fifo_level + 2'(do_push) - 2'(pop);
      if (overflow)  err_ovf <= 1'b1;
      if (underflow) err_udf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cbfp_shift_sched.sv
// Directed bench for cbfp_shift_sched: a per-cycle vector table of inputs and
// hand-computed registered outputs, plus hand-written bypass / full push+pop sequences.
module tb_cbfp_shift_sched;

  typedef struct {
    logic       rst;
    logic       zv;
    logic [4:0] z;
    logic       sv;
    logic       vld;
    logic [4:0] sh;
    logic [1:0] bt;
    logic       dn;
    logic [4:0] ex;
    logic [7:0] idx;
    logic [1:0] lvl;
    logic       ovf;
    logic       udf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       zcnt_valid = 1'b0;
  logic [4:0] zcnt_in = '0;
  logic       sr_valid = 1'b0;
  logic       scale_valid;
  logic [4:0] scale_shift;
  logic [1:0] scale_beat;
  logic       blk_done;
  logic [4:0] blk_exp;
  logic [7:0] blk_idx;
  logic [1:0] fifo_level;
  logic       err_ovf;
  logic       err_udf;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  cbfp_shift_sched dut (
    .clk         (clk),
    .rst         (rst),
    .zcnt_valid  (zcnt_valid),
    .zcnt_in     (zcnt_in),
    .sr_valid    (sr_valid),
    .scale_valid (scale_valid),
    .scale_shift (scale_shift),
    .scale_beat  (scale_beat),
    .blk_done    (blk_done),
    .blk_exp     (blk_exp),
    .blk_idx     (blk_idx),
    .fifo_level  (fifo_level),
    .err_ovf     (err_ovf),
    .err_udf     (err_udf)
  );

  function automatic vec_t mkVec(input logic r, input logic zv, input logic [4:0] z, input logic sv,
                                 input logic vld, input logic [4:0] sh, input logic [1:0] bt,
                                 input logic dn, input logic [4:0] ex, input logic [7:0] idx,
                                 input logic [1:0] lvl, input logic ovf, input logic udf);
    vec_t v;
    v.rst = r;  v.zv = zv;  v.z = z;   v.sv = sv;
    v.vld = vld; v.sh = sh; v.bt = bt; v.dn = dn; v.ex = ex;
    v.idx = idx; v.lvl = lvl; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  task automatic addIn(input logic [4:0] z, input logic [7:0] idx, input logic [1:0] lvl,
                       input logic ovf, input logic udf);
    vecs.push_back(mkVec(0, 1, z, 0, 0, 0, 0, 0, 0, idx, lvl, ovf, udf));
  endtask

  task automatic addGap(input logic [7:0] idx, input logic [1:0] lvl, input logic ovf, input logic udf);
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, idx, lvl, ovf, udf));
  endtask

  // Four sr_valid beats; the block completes (and blk_idx steps) on beat 3.
  task automatic addOutBlock(input logic [4:0] sh, input logic [7:0] idx0, input logic [1:0] lvl,
                             input logic ovf, input logic udf);
    for (int b = 0; b < 4; b++)
      vecs.push_back(mkVec(0, 0, 0, 1, 1, sh, 2'(b), (b == 3), sh,
                           (b == 3) ? idx0 + 8'd1 : idx0, lvl, ovf, udf));
  endtask

  task automatic applyStimulus(input vec_t v);
    rst        = v.rst;
    zcnt_valid = v.zv;
    zcnt_in    = v.z;
    sr_valid   = v.sv;
  endtask

  task automatic checkOutput(input vec_t e, input string name);
    logic bad;
    bad = (scale_valid !== e.vld) || (blk_done !== e.dn) || (blk_idx !== e.idx) ||
          (fifo_level !== e.lvl) || (err_ovf !== e.ovf) || (err_udf !== e.udf) ||
          (e.vld && ((scale_shift !== e.sh) || (scale_beat !== e.bt))) ||
          (e.dn && (blk_exp !== e.ex));
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL %s: got vld=%0b sh=%0d bt=%0d dn=%0b ex=%0d idx=%0d lvl=%0d ovf=%0b udf=%0b; want vld=%0b sh=%0d bt=%0d dn=%0b ex=%0d idx=%0d lvl=%0d ovf=%0b udf=%0b",
               name, scale_valid, scale_shift, scale_beat, blk_done, blk_exp, blk_idx, fifo_level,
               err_ovf, err_udf, e.vld, e.sh, e.bt, e.dn, e.ex, e.idx, e.lvl, e.ovf, e.udf);
    end
  endtask

  task automatic runCycle(input vec_t v, input string name);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput(v, name);
  endtask

  initial begin
    // T1: basic block, min 3
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addIn(7, 0, 0, 0, 0); addIn(3, 0, 0, 0, 0); addIn(9, 0, 0, 0, 0); addIn(5, 0, 1, 0, 0);
    addOutBlock(3, 0, 0, 0, 0);
    addGap(1, 0, 0, 0);
    // T2: min 18 clamps to 12
    addIn(20, 1, 0, 0, 0); addIn(18, 1, 0, 0, 0); addIn(22, 1, 0, 0, 0); addIn(19, 1, 1, 0, 0);
    addOutBlock(12, 1, 0, 0, 0);
    // T3: two blocks with input gaps, FIFO reaches 2
    addIn(8, 2, 0, 0, 0); addIn(2, 2, 0, 0, 0); addGap(2, 0, 0, 0); addIn(5, 2, 0, 0, 0); addIn(9, 2, 1, 0, 0);
    addIn(6, 2, 1, 0, 0); addGap(2, 1, 0, 0); addIn(7, 2, 1, 0, 0); addIn(10, 2, 1, 0, 0); addIn(6, 2, 2, 0, 0);
    addOutBlock(2, 2, 1, 0, 0);
    addOutBlock(6, 3, 0, 0, 0);
    // T4: underflow block uses shift 0, then a normal block (min 11)
    addOutBlock(0, 4, 0, 0, 1);
    addIn(11, 5, 0, 0, 1); addIn(12, 5, 0, 0, 1); addIn(13, 5, 0, 0, 1); addIn(11, 5, 1, 0, 1);
    addOutBlock(11, 5, 0, 0, 1);
    // T5: three pushes without pops, third dropped
    for (int i = 0; i < 4; i++) addIn(1, 6, (i == 3) ? 2'd1 : 2'd0, 0, 1);
    for (int i = 0; i < 4; i++) addIn(2, 6, (i == 3) ? 2'd2 : 2'd1, 0, 1);
    for (int i = 0; i < 4; i++) addIn(3, 6, 2, (i == 3), 1);
    addOutBlock(1, 6, 1, 1, 1);
    addOutBlock(2, 7, 0, 1, 1);
    addGap(8, 0, 1, 1);
    // T6: reset discards a partial block
    addIn(1, 8, 0, 1, 1); addIn(1, 8, 0, 1, 1);
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addIn(4, 0, 0, 0, 0); addIn(8, 0, 0, 0, 0); addIn(5, 0, 0, 0, 0); addIn(6, 0, 1, 0, 0);
    addOutBlock(4, 0, 0, 0, 0);

    foreach (vecs[i]) runCycle(vecs[i], $sformatf("vec%0d", i));

    // Bypass: last input beat and block start in the same cycle, FIFO empty.
    runCycle(mkVec(0, 1, 9, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "bypass_in0");
    runCycle(mkVec(0, 1, 7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "bypass_in1");
    runCycle(mkVec(0, 1, 8, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "bypass_in2");
    runCycle(mkVec(0, 1, 10, 1, 1, 7, 0, 0, 0, 1, 0, 0, 0), "bypass_beat0");
    for (int b = 1; b < 4; b++)
      runCycle(mkVec(0, 0, 0, 1, 1, 7, 2'(b), (b == 3), 7, (b == 3) ? 8'd2 : 8'd1, 0, 0, 0),
               $sformatf("bypass_beat%0d", b));

    // Full FIFO with simultaneous push and pop: level holds at 2, no overflow.
    for (int i = 0; i < 4; i++)
      runCycle(mkVec(0, 1, 5, 0, 0, 0, 0, 0, 0, 2, (i == 3) ? 2'd1 : 2'd0, 0, 0), $sformatf("full_a%0d", i));
    for (int i = 0; i < 4; i++)
      runCycle(mkVec(0, 1, 3, 0, 0, 0, 0, 0, 0, 2, (i == 3) ? 2'd2 : 2'd1, 0, 0), $sformatf("full_b%0d", i));
    for (int i = 0; i < 3; i++)
      runCycle(mkVec(0, 1, 9, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0), $sformatf("full_c%0d", i));
    runCycle(mkVec(0, 1, 9, 1, 1, 5, 0, 0, 0, 2, 2, 0, 0), "full_pushpop");
    for (int b = 1; b < 4; b++)
      runCycle(mkVec(0, 0, 0, 1, 1, 5, 2'(b), (b == 3), 5, (b == 3) ? 8'd3 : 8'd2, 2, 0, 0),
               $sformatf("full_blk5_b%0d", b));
    for (int b = 0; b < 4; b++)
      runCycle(mkVec(0, 0, 0, 1, 1, 3, 2'(b), (b == 3), 3, (b == 3) ? 8'd4 : 8'd3, 1, 0, 0),
               $sformatf("full_blk3_b%0d", b));
    for (int b = 0; b < 4; b++)
      runCycle(mkVec(0, 0, 0, 1, 1, 9, 2'(b), (b == 3), 9, (b == 3) ? 8'd5 : 8'd4, 0, 0, 0),
               $sformatf("full_blk9_b%0d", b));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
